// File: rtl/mii_pkg.sv
// Shared line codes, TX word constants and scheduler state type for the 64-bit MII TX path.
package mii_pkg;

  localparam logic [7:0] IDLE_CODE     = 8'h07;
  localparam logic [7:0] START_CODE    = 8'hFB;
  localparam logic [7:0] EOF_CODE      = 8'hFD;
  localparam logic [7:0] PREAMBLE_CODE = 8'h55;

  localparam int MIN_PAYLOAD_CYCLES = 5;
  localparam int MAX_PAYLOAD_CYCLES = 17;

  // Lane 0 is the least significant byte of the 64-bit word.
  localparam logic [63:0] IDLE_WORD  = {8{IDLE_CODE}};
  localparam logic [63:0] START_WORD = {{7{PREAMBLE_CODE}}, START_CODE};
  localparam logic [63:0] EOF_WORD   = {EOF_CODE, {7{IDLE_CODE}}};

  localparam logic [7:0] CTRL_IDLE  = 8'hFF;
  localparam logic [7:0] CTRL_START = 8'h01;
  localparam logic [7:0] CTRL_DATA  = 8'h00;
  localparam logic [7:0] CTRL_EOF   = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    START,
    PAYLOAD,
    EOF,
    IFG
  } sched_state_t;

  function automatic logic len_in_range(input int len);
    return (len >= MIN_PAYLOAD_CYCLES) && (len <= MAX_PAYLOAD_CYCLES);
  endfunction

endpackage

// File: rtl/mii_rr_arbiter.sv
// Rotate-priority pick: the first requester after rr_ptr (mod N_REQ) with its request set wins.
module mii_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    int  cand;
    logic found;
    // NOTE: every output gets a default before the loop so no latch is inferred.
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = (int'(rr_ptr) + i) % N_REQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mii_tx_scheduler.sv
// Round-robin frame scheduler sharing one 64-bit MII TX lane: START / payload / EOF framing,
// inter-frame gap enforcement and payload length rejection.
module mii_tx_scheduler
  import mii_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8,
  parameter int N_REQ      = 2,
  parameter int LEN_W      = 5,
  parameter int IFG_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        i_rst,
  input  logic [N_REQ-1:0]            i_req,
  input  logic [N_REQ*LEN_W-1:0]      i_len,
  input  logic [N_REQ*DATA_WIDTH-1:0] i_data,
  output logic [N_REQ-1:0]            o_pop,
  output logic [N_REQ-1:0]            o_grant,
  output logic [N_REQ-1:0]            o_done,
  output logic                        o_len_err,
  output logic                        o_busy,
  output logic [DATA_WIDTH-1:0]       o_tx_data,
  output logic [CTRL_WIDTH-1:0]       o_tx_ctrl
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  sched_state_t     state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] g;
  logic [N_REQ-1:0] grant_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] wcnt;
  logic [IFG_W-1:0] ifg_cnt;
  logic             rej_q;

  logic [N_REQ-1:0] arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic [LEN_W-1:0] len_sel;

  mii_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req    (i_req),
    .rr_ptr (rr_ptr),
    .grant  (arb_grant),
    .idx    (arb_idx)
  );

  assign len_sel = i_len[arb_idx*LEN_W +: LEN_W];

  // rej_q blocks arbitration for one cycle so the rejected requester can drop i_req after o_done.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state     <= IDLE;
      rr_ptr    <= IDX_W'(N_REQ - 1);
      g         <= '0;
      grant_q   <= '0;
      len_q     <= '0;
      wcnt      <= '0;
      ifg_cnt   <= '0;
      rej_q     <= 1'b0;
      o_tx_data <= IDLE_WORD;
      o_tx_ctrl <= CTRL_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      rej_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!rej_q && (|arb_grant)) begin
            g       <= arb_idx;
            grant_q <= arb_grant;
            if (len_in_range(int'(len_sel))) begin
              len_q <= len_sel;
              wcnt  <= '0;
              state <= START;
            end else begin
              rej_q  <= 1'b1;
              rr_ptr <= arb_idx;
            end
          end
        end
        START: state <= PAYLOAD;
        PAYLOAD: begin
          if (wcnt == len_q - LEN_W'(1)) state <= EOF;
          else                           wcnt  <= wcnt + LEN_W'(1);
        end
        EOF: begin
          rr_ptr  <= g;
          wcnt    <= '0;
          ifg_cnt <= '0;
          state   <= IFG;
        end
        IFG: begin
          if (ifg_cnt == IFG_W'(IFG_CYCLES - 1)) state   <= IDLE;
          else                                   ifg_cnt <= ifg_cnt + IFG_W'(1);
        end
        default: state <= IDLE;
      endcase

      // TX word reflects the state of the cycle just ending.
      case (state)
        START: begin
          o_tx_data <= START_WORD;
          o_tx_ctrl <= CTRL_START;
        end
        PAYLOAD: begin
          o_tx_data <= i_data[g*DATA_WIDTH +: DATA_WIDTH];
          o_tx_ctrl <= CTRL_DATA;
        end
        EOF: begin
          o_tx_data <= EOF_WORD;
          o_tx_ctrl <= CTRL_EOF;
        end
        default: begin
          o_tx_data <= IDLE_WORD;
          o_tx_ctrl <= CTRL_IDLE;
        end
      endcase
    end
  end

  assign o_busy    = (state != IDLE);
  assign o_grant   = (state == START || state == PAYLOAD || state == EOF) ? grant_q : '0;
  assign o_pop     = (state == PAYLOAD) ? grant_q : '0;
  assign o_done    = (state == EOF || rej_q) ? grant_q : '0;
  assign o_len_err = rej_q;

endmodule
